// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and helpers for the MIPS pipeline
package mips_pkg;

    localparam int DATA_W = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LOAD = 2'd1,
        RES_LINK = 2'd2,
        RES_RSVD = 2'd3
    } resSel_t;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2,
        LS_RSVD = 2'd3
    } loadSize_t;

    // Halfwords need an even address; words and the reserved size need a word address.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLow);
        logic mis;
        case (size)
            LS_BYTE: mis = 1'b0;
            LS_HALF: mis = addrLow[0];
            default: mis = (addrLow != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - MEM to WB retiring-instruction handshake bundle
interface writeback_unit_if;

    logic                        InValid;
    logic                        InReady;
    logic                        InRegWrite;
    logic [4:0]                  InDestReg;
    logic [1:0]                  InResultSel;
    logic [mips_pkg::DATA_W-1:0] InAluResult;
    logic [mips_pkg::DATA_W-1:0] InPcPlus4;
    logic [1:0]                  InLoadSize;
    logic                        InLoadSigned;

    modport master (
        output InValid, InRegWrite, InDestReg, InResultSel,
               InAluResult, InPcPlus4, InLoadSize, InLoadSigned,
        input  InReady
    );

    modport slave (
        input  InValid, InRegWrite, InDestReg, InResultSel,
               InAluResult, InPcPlus4, InLoadSize, InLoadSigned,
        output InReady
    );

endinterface

// File: rtl/writeback_unit_align.sv
// rtl/writeback_unit_align.sv - picks the addressed byte/half lane of a load word and extends it
module load_align
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        addrLow,
    input  logic [1:0]        size,
    input  logic              signedExt,
    output logic [DATA_W-1:0] value
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Little-endian lane select followed by zero or sign extension to the register width
    always_comb begin
        byteLane = word[{addrLow, 3'b000} +: 8];
        halfLane = addrLow[1] ? word[31:16] : word[15:0];
        case (size)
            LS_BYTE: value = {{24{signedExt & byteLane[7]}}, byteLane};
            LS_HALF: value = {{16{signedExt & halfLane[15]}}, halfLane};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - WB stage: result select, load wait/align, register write port
module writeback_unit
    import mips_pkg::*;
#(
    parameter int LOAD_LAT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    writeback_unit_if.slave   inBus,
    input  logic              Flush,
    input  logic              MemRspValid,
    input  logic [DATA_W-1:0] MemRspData,
    output logic [DATA_W-1:0] WriteData,
    output logic [4:0]        WriteReg,
    output logic              RegWriteActive,
    output logic              PendValid,
    output logic [4:0]        PendReg,
    output logic              AlignErr,
    output logic              LoadTimeout,
    output logic [15:0]       RetiredCount
);

    localparam int WdW = $clog2(LOAD_LAT_MAX + 1);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t            state;
    logic [1:0]        ldAddrLow;
    logic [1:0]        ldSize;
    logic              ldSigned;
    logic              ldRegWrite;
    logic [WdW-1:0]    watchdog;
    logic [WdW-1:0]    wdNext;
    logic              accept;
    logic              isLoad;
    logic [DATA_W-1:0] loadValue;
    logic [DATA_W-1:0] nonLoadValue;

    assign inBus.InReady = (state == IDLE) & ~Flush;
    assign accept        = inBus.InValid & inBus.InReady;
    assign isLoad        = (inBus.InResultSel == RES_LOAD);
    assign wdNext        = watchdog + 1'b1;
    assign nonLoadValue  = (inBus.InResultSel == RES_LINK) ? inBus.InPcPlus4 : inBus.InAluResult;

    load_align uAlign (
        .word      (MemRspData),
        .addrLow   (ldAddrLow),
        .size      (ldSize),
        .signedExt (ldSigned),
        .value     (loadValue)
    );

    // Stage FSM: registered write port, load tracking, watchdog and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            WriteData      <= '0;
            WriteReg       <= REG_ZERO;
            RegWriteActive <= 1'b0;
            PendValid      <= 1'b0;
            PendReg        <= REG_ZERO;
            AlignErr       <= 1'b0;
            LoadTimeout    <= 1'b0;
            RetiredCount   <= '0;
            watchdog       <= '0;
            ldAddrLow      <= '0;
            ldSize         <= '0;
            ldSigned       <= 1'b0;
            ldRegWrite     <= 1'b0;
        end else begin
            RegWriteActive <= 1'b0;
            AlignErr       <= 1'b0;
            LoadTimeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && isLoad) begin
                        ldAddrLow  <= inBus.InAluResult[1:0];
                        ldSize     <= inBus.InLoadSize;
                        ldSigned   <= inBus.InLoadSigned;
                        ldRegWrite <= inBus.InRegWrite;
                        if (isMisaligned(inBus.InLoadSize, inBus.InAluResult[1:0])) begin
                            AlignErr     <= 1'b1;
                            RetiredCount <= RetiredCount + 16'd1;
                        end else begin
                            state     <= WAIT_LOAD;
                            PendValid <= 1'b1;
                            PendReg   <= inBus.InDestReg;
                            watchdog  <= '0;
                        end
                    end else if (accept) begin
                        RetiredCount <= RetiredCount + 16'd1;
                        if (inBus.InRegWrite && (inBus.InDestReg != REG_ZERO)) begin
                            RegWriteActive <= 1'b1;
                            WriteReg       <= inBus.InDestReg;
                            WriteData      <= nonLoadValue;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (Flush) begin
                        state     <= IDLE;
                        PendValid <= 1'b0;
                    end else if (MemRspValid) begin
                        state        <= IDLE;
                        PendValid    <= 1'b0;
                        RetiredCount <= RetiredCount + 16'd1;
                        if (ldRegWrite && (PendReg != REG_ZERO)) begin
                            RegWriteActive <= 1'b1;
                            WriteReg       <= PendReg;
                            WriteData      <= loadValue;
                        end
                    end else if (wdNext == WdW'(LOAD_LAT_MAX)) begin
                        state       <= IDLE;
                        PendValid   <= 1'b0;
                        LoadTimeout <= 1'b1;
                    end else begin
                        watchdog <= wdNext;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Flush = 1'b0;
    logic        MemRspValid = 1'b0;
    logic [31:0] MemRspData = '0;
    logic [31:0] WriteData;
    logic [4:0]  WriteReg;
    logic        RegWriteActive;
    logic        PendValid;
    logic [4:0]  PendReg;
    logic        AlignErr;
    logic        LoadTimeout;
    logic [15:0] RetiredCount;

    int errors = 0;
    int checks = 0;

    writeback_unit_if wbIf();

    writeback_unit #(.LOAD_LAT_MAX(15)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inBus          (wbIf),
        .Flush          (Flush),
        .MemRspValid    (MemRspValid),
        .MemRspData     (MemRspData),
        .WriteData      (WriteData),
        .WriteReg       (WriteReg),
        .RegWriteActive (RegWriteActive),
        .PendValid      (PendValid),
        .PendReg        (PendReg),
        .AlignErr       (AlignErr),
        .LoadTimeout    (LoadTimeout),
        .RetiredCount   (RetiredCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          mBusy = 0;
    logic [4:0]  mDest = '0;
    bit          mRw = 0;
    logic [1:0]  mAddr = '0;
    logic [1:0]  mSize = '0;
    bit          mSgn = 0;
    int          mWaited = 0;
    bit          eWA = 0, eAE = 0, eTO = 0;
    logic [31:0] eWD = '0;
    logic [4:0]  eWR = '0;
    logic [15:0] eRet = '0;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] addr,
                                            input logic [1:0] size, input bit sgn);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (word >> (8 * addr)) & 32'hFF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (word >> (8 * addr)) & 32'hFFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic bit misaligned(input logic [1:0] size, input logic [1:0] addr);
        if (size == 2'd0) return 0;
        if (size == 2'd1) return (addr % 2) != 0;
        return addr != 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy = 0; mWaited = 0; mDest = '0;
            eWA = 0; eAE = 0; eTO = 0; eWD = '0; eWR = '0; eRet = '0;
        end else begin
            eWA = 0; eAE = 0; eTO = 0;
            if (mBusy) begin
                if (Flush) begin
                    mBusy = 0;
                end else if (MemRspValid) begin
                    mBusy = 0;
                    eRet = eRet + 1;
                    if (mRw && mDest != 0) begin
                        eWA = 1; eWR = mDest; eWD = extract(MemRspData, mAddr, mSize, mSgn);
                    end
                end else begin
                    mWaited++;
                    if (mWaited == 15) begin
                        mBusy = 0; eTO = 1;
                    end
                end
            end else if (wbIf.InValid && !Flush) begin
                if (wbIf.InResultSel == 2'd1) begin
                    if (misaligned(wbIf.InLoadSize, wbIf.InAluResult[1:0])) begin
                        eAE = 1; eRet = eRet + 1;
                    end else begin
                        mBusy = 1; mWaited = 0;
                        mDest = wbIf.InDestReg; mRw = wbIf.InRegWrite;
                        mAddr = wbIf.InAluResult[1:0]; mSize = wbIf.InLoadSize;
                        mSgn = wbIf.InLoadSigned;
                    end
                end else begin
                    eRet = eRet + 1;
                    if (wbIf.InRegWrite && wbIf.InDestReg != 0) begin
                        eWA = 1; eWR = wbIf.InDestReg;
                        eWD = (wbIf.InResultSel == 2'd2) ? wbIf.InPcPlus4 : wbIf.InAluResult;
                    end
                end
            end
        end
    end

    // Per-cycle compare of every DUT output against the model
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            check("cmp RegWriteActive", RegWriteActive, eWA);
            check("cmp WriteData", WriteData, eWD);
            check("cmp WriteReg", WriteReg, eWR);
            check("cmp AlignErr", AlignErr, eAE);
            check("cmp LoadTimeout", LoadTimeout, eTO);
            check("cmp RetiredCount", RetiredCount, eRet);
            check("cmp PendValid", PendValid, mBusy);
            if (mBusy) check("cmp PendReg", PendReg, mDest);
            check("cmp InReady", wbIf.InReady, !mBusy && !Flush);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit rw, input logic [4:0] dest, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [1:0] size,
                         input bit sgn, input bit fl, input bit rv, input logic [31:0] rd);
        @(negedge clk);
        wbIf.InValid = v; wbIf.InRegWrite = rw; wbIf.InDestReg = dest;
        wbIf.InResultSel = sel; wbIf.InAluResult = alu; wbIf.InPcPlus4 = pc;
        wbIf.InLoadSize = size; wbIf.InLoadSigned = sgn;
        Flush = fl; MemRspValid = rv; MemRspData = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit fl, input bit rv, input logic [31:0] rd);
        drive(0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 2'd0, 0, fl, rv, rd);
    endtask

    initial begin
        drive(0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 2'd0, 0, 0, 0, 32'h0);
        idle(0, 0, 32'h0);
        check("reset RegWriteActive", RegWriteActive, 0);
        check("reset WriteData", WriteData, 0);
        check("reset RetiredCount", RetiredCount, 0);
        check("reset PendValid", PendValid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU op to r5
        drive(1, 1, 5'd5, 2'd0, 32'h1234_5678, 32'h0, 2'd0, 0, 0, 0, 32'h0);
        check("alu RegWriteActive", RegWriteActive, 1);
        check("alu WriteReg", WriteReg, 5);
        check("alu WriteData", WriteData, 32'h1234_5678);
        check("alu RetiredCount", RetiredCount, 1);
        idle(0, 0, 32'h0);
        check("alu strobe one cycle", RegWriteActive, 0);

        // Signed byte load, lane 3, response on the fourth wait cycle
        drive(1, 1, 5'd7, 2'd1, 32'h0000_1003, 32'h0, 2'd0, 1, 0, 0, 32'h0);
        check("lb PendValid", PendValid, 1);
        check("lb PendReg", PendReg, 7);
        check("lb InReady", wbIf.InReady, 0);
        for (int i = 0; i < 3; i++) begin
            idle(0, 0, 32'h0);
            check("lb PendReg wait", PendReg, 7);
        end
        idle(0, 1, 32'h80FF_0000);
        check("lb RegWriteActive", RegWriteActive, 1);
        check("lb WriteData", WriteData, 32'hFFFF_FF80);
        check("lb WriteReg", WriteReg, 7);
        check("lb PendValid drop", PendValid, 0);
        check("lb RetiredCount", RetiredCount, 2);

        // Misaligned unsigned half
        drive(1, 1, 5'd9, 2'd1, 32'h0000_2001, 32'h0, 2'd1, 0, 0, 0, 32'h0);
        check("lh AlignErr", AlignErr, 1);
        check("lh RegWriteActive", RegWriteActive, 0);
        check("lh RetiredCount", RetiredCount, 3);
        check("lh InReady", wbIf.InReady, 1);

        // r0 destination, then link to r31
        drive(1, 1, 5'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 2'd0, 0, 0, 0, 32'h0);
        check("r0 RegWriteActive", RegWriteActive, 0);
        check("r0 RetiredCount", RetiredCount, 4);
        check("r0 WriteData hold", WriteData, 32'hFFFF_FF80);
        drive(1, 1, 5'd31, 2'd2, 32'h0000_0055, 32'h0040_0010, 2'd0, 0, 0, 0, 32'h0);
        check("link WriteReg", WriteReg, 31);
        check("link WriteData", WriteData, 32'h0040_0010);
        check("link RetiredCount", RetiredCount, 5);

        // Flush beats a same-cycle response
        drive(1, 1, 5'd4, 2'd1, 32'h0000_0100, 32'h0, 2'd2, 0, 0, 0, 32'h0);
        idle(0, 0, 32'h0);
        idle(1, 1, 32'h1111_1111);
        check("flush RegWriteActive", RegWriteActive, 0);
        check("flush PendValid", PendValid, 0);
        check("flush RetiredCount", RetiredCount, 5);
        idle(0, 0, 32'h0);
        check("flush InReady", wbIf.InReady, 1);

        // Watchdog expiry after 15 silent cycles
        drive(1, 1, 5'd6, 2'd1, 32'h0000_0200, 32'h0, 2'd2, 0, 0, 0, 32'h0);
        for (int i = 0; i < 14; i++) begin
            idle(0, 0, 32'h0);
            check("to early LoadTimeout", LoadTimeout, 0);
        end
        idle(0, 0, 32'h0);
        check("to LoadTimeout", LoadTimeout, 1);
        check("to PendValid", PendValid, 0);
        check("to RegWriteActive", RegWriteActive, 0);
        check("to RetiredCount", RetiredCount, 5);
        idle(0, 0, 32'h0);
        check("to pulse one cycle", LoadTimeout, 0);

        // Asynchronous reset during a load
        drive(1, 1, 5'd8, 2'd1, 32'h0000_0300, 32'h0, 2'd0, 0, 0, 0, 32'h0);
        idle(0, 0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst PendValid", PendValid, 0);
        check("arst PendReg", PendReg, 0);
        check("arst WriteData", WriteData, 0);
        check("arst WriteReg", WriteReg, 0);
        check("arst RetiredCount", RetiredCount, 0);
        check("arst InReady", wbIf.InReady, 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(0, 0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 9) < 7),
                  $urandom_range(0, 7) != 0,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  2'($urandom_range(0, 3)),
                  $urandom,
                  $urandom,
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) != 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom);
        end
        idle(0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
